// File: rtl/uart_tx_buffer.sv
// rtl/uart_tx_buffer.sv - byte FIFO and issue/Busy-tracking sequencer ahead of the UART transmitter
module uart_tx_buffer #(
    parameter int width   = 8,
    parameter int DEPTH   = 16,
    parameter int BUSY_TO = 3
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [width-1:0]           WR_DATA,
    input  logic                       WR_EN,
    output logic                       FULL,
    output logic                       EMPTY,
    output logic [$clog2(DEPTH):0]     FIFO_CNT,
    output logic                       OVF,
    output logic [width-1:0]           TX_P_DATA,
    output logic                       TX_D_VLD,
    input  logic                       Busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(BUSY_TO + 1);

    typedef enum logic [1:0] {IDLE, WAIT_HI, WAIT_LO} state_t;

    logic [width-1:0] mem [DEPTH];

    state_t           state_q, state_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [TW-1:0]    to_q, to_d;
    logic [width-1:0] data_q, data_d;
    logic             vld_q, vld_d;
    logic             ovf_q, ovf_d;
    logic             wr_accept;
    logic             pop;

    assign FULL      = (cnt_q == CW'(DEPTH));
    assign EMPTY     = (cnt_q == '0);
    assign FIFO_CNT  = cnt_q;
    assign OVF       = ovf_q;
    assign TX_P_DATA = data_q;
    assign TX_D_VLD  = vld_q;

    // Space freed by a same-cycle pop is not visible to the write.
    assign wr_accept = WR_EN && !FULL;
    assign pop       = (state_q == IDLE) && !EMPTY && !Busy;

    always_comb begin
        state_d  = state_q;
        to_d     = to_q;
        data_d   = data_q;
        vld_d    = 1'b0;
        ovf_d    = WR_EN && FULL;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;

        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({wr_accept, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase

        case (state_q)
            IDLE: begin
                if (pop) begin
                    state_d = WAIT_HI;
                    to_d    = '0;
                    vld_d   = 1'b1;
                    data_d  = mem[rd_ptr_q];
                end
            end
            WAIT_HI: begin
                if (Busy) begin
                    state_d = WAIT_LO;
                end else begin
                    to_d = to_q + TW'(1);
                    // Transmitter never acknowledged: treat the byte as consumed.
                    if (to_d == TW'(BUSY_TO)) begin
                        state_d = IDLE;
                    end
                end
            end
            WAIT_LO: begin
                if (!Busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            to_q     <= '0;
            data_q   <= '0;
            vld_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            to_q     <= to_d;
            data_q   <= data_d;
            vld_q    <= vld_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_accept) begin
            mem[wr_ptr_q] <= WR_DATA;
        end
    end
endmodule

// File: tb/tb_uart_tx_buffer.sv
// tb/tb_uart_tx_buffer.sv - randomized and directed bench for uart_tx_buffer against a queue model
module tb_uart_tx_buffer;
    localparam int W       = 8;
    localparam int DEPTH   = 16;
    localparam int BUSY_TO = 3;

    logic                   CLK = 1'b0;
    logic                   RST = 1'b0;
    logic [W-1:0]           WR_DATA = '0;
    logic                   WR_EN = 1'b0;
    logic                   FULL, EMPTY, OVF, TX_D_VLD;
    logic [$clog2(DEPTH):0] FIFO_CNT;
    logic [W-1:0]           TX_P_DATA;
    logic                   Busy = 1'b0;

    uart_tx_buffer #(.width(W), .DEPTH(DEPTH), .BUSY_TO(BUSY_TO)) dut (
        .CLK(CLK), .RST(RST), .WR_DATA(WR_DATA), .WR_EN(WR_EN),
        .FULL(FULL), .EMPTY(EMPTY), .FIFO_CNT(FIFO_CNT), .OVF(OVF),
        .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .Busy(Busy)
    );

    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a byte queue plus "waiting for Busy high" budget and "waiting for Busy low" flag.
    byte unsigned mq[$];
    int           hi_left = 0;
    bit           lo_wait = 1'b0;
    logic [W-1:0] m_data  = '0;
    bit           m_vld   = 1'b0;
    bit           m_ovf   = 1'b0;

    function automatic bit m_idle();
        return (hi_left == 0) && !lo_wait;
    endfunction

    task automatic model_reset();
        mq.delete();
        hi_left = 0;
        lo_wait = 1'b0;
        m_data  = '0;
        m_vld   = 1'b0;
        m_ovf   = 1'b0;
    endtask

    task automatic model_edge();
        bit pop;
        bit was_full;
        if (!RST) begin
            model_reset();
            return;
        end
        pop      = m_idle() && (mq.size() != 0) && !Busy;
        was_full = (mq.size() == DEPTH);
        m_ovf    = WR_EN && was_full;
        m_vld    = pop;
        if (pop) begin
            m_data  = mq.pop_front();
            hi_left = BUSY_TO;
        end else if (hi_left > 0) begin
            if (Busy) begin
                hi_left = 0;
                lo_wait = 1'b1;
            end else begin
                hi_left--;
            end
        end else if (lo_wait && !Busy) begin
            lo_wait = 1'b0;
        end
        if (WR_EN && !was_full) mq.push_back(WR_DATA);
    endtask

    // Transmitter model. mode 0: fixed delay/length, 1: never busy, 2: stuck busy, 3: random per frame.
    int busy_mode  = 1;
    int busy_delay = 2;
    int busy_len   = 10;
    int rise_in    = 0;
    int hold_left  = 0;

    task automatic busy_mode_set(input int mode, input int dly, input int len);
        busy_mode  = mode;
        busy_delay = dly;
        busy_len   = len;
        rise_in    = 0;
        hold_left  = 0;
        Busy       = (mode == 2);
    endtask

    task automatic drive_busy();
        if (!RST || busy_mode == 1) begin
            rise_in = 0; hold_left = 0; Busy = 1'b0;
        end else if (busy_mode == 2) begin
            Busy = 1'b1;
        end else begin
            if (TX_D_VLD) begin
                if (busy_mode == 3) begin
                    busy_delay = $urandom_range(1, 5);
                    busy_len   = $urandom_range(0, 6);
                end
                rise_in = busy_delay;
            end
            if (rise_in > 0) begin
                rise_in--;
                if (rise_in == 0) hold_left = busy_len;
            end
            Busy = (hold_left > 0);
            if (hold_left > 0) hold_left--;
        end
    endtask

    byte unsigned seen[$];
    int           cyc          = 0;
    int           last_strobe  = 0;
    int           strobe_busy  = 0;

    // One clock: inputs already set at the negedge, model follows the edge, outputs compared 1ns later.
    task automatic cycle();
        bit busy_at_edge;
        @(posedge CLK);
        busy_at_edge = Busy;
        model_edge();
        cyc++;
        #1;
        check_eq("fifo_cnt", FIFO_CNT, mq.size());
        check_eq("full", FULL, mq.size() == DEPTH);
        check_eq("empty", EMPTY, mq.size() == 0);
        check_eq("ovf", OVF, m_ovf);
        check_eq("tx_d_vld", TX_D_VLD, m_vld);
        check_eq("tx_p_data", TX_P_DATA, m_data);
        if (TX_D_VLD === 1'b1) begin
            seen.push_back(TX_P_DATA);
            last_strobe = cyc;
            if (busy_at_edge) strobe_busy++;
        end
        @(negedge CLK);
        drive_busy();
    endtask

    task automatic write_byte(input logic [W-1:0] d);
        WR_EN = 1'b1; WR_DATA = d;
        cycle();
        WR_EN = 1'b0;
    endtask

    task automatic drain(input int max_cyc);
        int n = 0;
        WR_EN = 1'b0;
        while (!(m_idle() && mq.size() == 0 && !Busy && rise_in == 0 && hold_left == 0)) begin
            if (n >= max_cyc) begin
                check_eq("drain_timeout", 0, 1);
                return;
            end
            cycle();
            n++;
        end
    endtask

    initial begin
        int n;
        int first_strobe;
        @(negedge CLK);
        model_reset();
        cycle();
        cycle();
        RST = 1'b1;
        cycle();

        // Single byte: 2-cycle enqueue-to-issue latency.
        busy_mode_set(0, 2, 4);
        write_byte(8'hA5);
        cycle();
        check_eq("single_vld", TX_D_VLD, 1);
        check_eq("single_data", TX_P_DATA, 8'hA5);
        check_eq("single_cnt", FIFO_CNT, 0);
        drain(100);

        // Burst of 4 against a long Busy window.
        seen.delete(); strobe_busy = 0;
        busy_mode_set(0, 2, 10);
        for (int i = 1; i <= 4; i++) write_byte(W'(i));
        drain(200);
        check_eq("burst_n", seen.size(), 4);
        for (int i = 0; i < 4 && i < seen.size(); i++) check_eq("burst_order", seen[i], i + 1);
        check_eq("burst_strobe_in_busy", strobe_busy, 0);

        // Fill and overflow with the transmitter stuck busy.
        seen.delete();
        busy_mode_set(2, 0, 0);
        for (int i = 1; i <= 16; i++) write_byte(W'(i));
        check_eq("fill_full", FULL, 1);
        check_eq("fill_cnt", FIFO_CNT, 16);
        write_byte(8'hEE);
        check_eq("ovf_pulse", OVF, 1);
        check_eq("ovf_cnt", FIFO_CNT, 16);
        cycle();
        check_eq("ovf_one_cycle", OVF, 0);
        busy_mode_set(0, 2, 3);
        drain(2000);
        check_eq("drain_n", seen.size(), 16);
        for (int i = 0; i < 16 && i < seen.size(); i++) check_eq("drain_order", seen[i], i + 1);

        // Hold occupancy at 3 with writes coinciding with pops, long enough to wrap the pointers.
        busy_mode_set(2, 0, 0);
        for (int i = 0; i < 3; i++) write_byte(W'($urandom));
        busy_mode_set(0, 2, 2);
        for (int i = 0; i < 200; i++) begin
            WR_EN   = m_idle() && (mq.size() != 0) && !Busy;
            WR_DATA = W'($urandom);
            cycle();
            check_eq("simul_cnt3", FIFO_CNT, 3);
        end
        drain(300);

        // Busy never rises: timeout, then the next byte issues right after.
        busy_mode_set(1, 0, 0);
        write_byte(8'h5A);
        write_byte(8'hC3);
        n = 0;
        while (!TX_D_VLD && n < 10) begin cycle(); n++; end
        first_strobe = last_strobe;
        n = 0;
        cycle();
        while (!TX_D_VLD && n < 20) begin cycle(); n++; end
        check_eq("timeout_gap", last_strobe - first_strobe, BUSY_TO + 1);
        check_eq("timeout_data2", TX_P_DATA, 8'hC3);
        drain(100);

        // Random traffic with random transmitter timing, including timeouts.
        busy_mode_set(3, 2, 2);
        for (int i = 0; i < 2000; i++) begin
            WR_EN   = ($urandom_range(0, 99) < 40);
            WR_DATA = W'($urandom);
            cycle();
        end
        WR_EN = 1'b0;
        drain(3000);

        // Reset while waiting for Busy low with bytes still queued.
        busy_mode_set(0, 2, 10);
        for (int i = 0; i < 5; i++) write_byte(W'(8'h30 + i));
        n = 0;
        while (!lo_wait && n < 50) begin cycle(); n++; end
        check_eq("reach_wait_lo", lo_wait, 1);
        cycle();
        #2;
        RST = 1'b0;
        #1;
        check_eq("rst_vld", TX_D_VLD, 0);
        check_eq("rst_data", TX_P_DATA, 0);
        check_eq("rst_ovf", OVF, 0);
        check_eq("rst_empty", EMPTY, 1);
        check_eq("rst_full", FULL, 0);
        check_eq("rst_cnt", FIFO_CNT, 0);
        model_reset();
        @(negedge CLK);
        busy_mode_set(1, 0, 0);
        cycle();
        cycle();
        RST = 1'b1;
        seen.delete();
        for (int i = 0; i < 20; i++) cycle();
        check_eq("post_rst_no_issue", seen.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx_buffer.md
# uart_tx_buffer

Byte FIFO and handshake sequencer that sits directly upstream of the UART transmitter. It accepts bytes from the host side at any rate up to one per clock, stores up to DEPTH of them, and presents them one at a time on TX_P_DATA/TX_D_VLD. Each byte is issued only when the transmitter's Busy is low, and the block then tracks Busy through a full frame before issuing the next byte. It runs on the transmitter's clock domain.

## Interface
- width, 8: data byte width; must match the transmitter's width.
- DEPTH, 16: FIFO entries; power of two, minimum 2.
- BUSY_TO, 3: cycles to wait for Busy to rise after a TX_D_VLD pulse before abandoning the wait.

- CLK  in  1  transmitter clock (same clock as CLK_TX); all logic is rising-edge.
- RST  in  1  asynchronous, active-low reset.
- WR_DATA  in  width  byte to enqueue.
- WR_EN  in  1  enqueue request; sampled every rising edge.
- FULL  out  1  FIFO holds DEPTH entries.
- EMPTY  out  1  FIFO holds 0 entries.
- FIFO_CNT  out  log2(DEPTH)+1  current occupancy.
- OVF  out  1  one-cycle pulse when a write is dropped.
- TX_P_DATA  out  width  byte to the transmitter; registered.
- TX_D_VLD  out  1  one-cycle issue strobe to the transmitter; registered.
- Busy  in  1  transmitter busy flag.

## Operation
- FIFO
  - Circular buffer with read and write pointers of log2(DEPTH) bits each; pointers wrap modulo DEPTH.
  - Occupancy is held in a separate counter, FIFO_CNT, with FULL = (FIFO_CNT==DEPTH) and EMPTY = (FIFO_CNT==0).
  - A write is accepted only when WR_EN=1 and FULL=0 at the sampling edge. A pop in the same cycle does not free space for that write.
  - When WR_EN=1 and FULL=1, the write is dropped and OVF pulses high for the next cycle. Storage and pointers are unchanged.
  - A simultaneous accepted write and pop leaves FIFO_CNT unchanged.
- Sequencer FSM, states IDLE, WAIT_HI, WAIT_LO
  - IDLE: if EMPTY=0 and Busy=0, register the head byte onto TX_P_DATA, assert TX_D_VLD for exactly one cycle, pop the head, and go to WAIT_HI with the timeout counter cleared. Otherwise stay in IDLE.
  - WAIT_HI: if Busy=1, go to WAIT_LO. Otherwise increment the timeout counter; when it reaches BUSY_TO, go to IDLE (the byte counts as consumed).
  - WAIT_LO: on Busy=0, go to IDLE.
  - TX_P_DATA holds its last issued value in all states; it changes only when a byte is issued.
- Reset (RST=0, asynchronous)
  - Pointers, FIFO_CNT, and timeout counter go to 0; FSM goes to IDLE.
  - Outputs: TX_D_VLD=0, TX_P_DATA=0, OVF=0, EMPTY=1, FULL=0, FIFO_CNT=0.
  - Reset asserted mid-frame discards all queued bytes. No issue occurs until RST is released and the FIFO is refilled.
- Storage array is not reset.

## Timing
- Write sampled at edge n:
  - FIFO_CNT and EMPTY update after edge n.
  - If the FSM is in IDLE with Busy=0, TX_D_VLD is high in the cycle following edge n+1, giving 2-cycle enqueue-to-issue latency.
- Busy is sampled, not edge-detected. If Busy is high while in IDLE, the issue is held until Busy is low.
- Back-to-back issues are separated by at least 3 cycles: strobe, Busy-high observation, Busy-low observation.
- Timeout path: TX_D_VLD pulse followed by BUSY_TO cycles with no Busy seen, then IDLE; the next issue may occur on the following edge.
- OVF: registered; high for one cycle per dropped write.

## Test plan
- Reset mid-operation: load 5 bytes, assert RST=0 while in WAIT_LO. Expect all outputs at reset values immediately (asynchronous), FIFO_CNT=0, and no TX_D_VLD after release.
- Single byte: write 0xA5 with Busy=0. Expect TX_D_VLD high for one cycle 2 cycles later with TX_P_DATA=0xA5, FIFO_CNT returning to 0.
- Burst of 4 bytes (0x01..0x04) against a transmitter model that asserts Busy 1 cycle after the strobe and holds it for 10 cycles. Expect 4 strobes in order, each only after Busy has fallen, and never two strobes within one Busy window.
- Fill and overflow with DEPTH=16 and Busy held at 1: write 17 bytes. Expect FULL=1 after the 16th write, one OVF pulse, and FIFO_CNT=16. After releasing Busy, expect bytes 1..16 drained in order.
- Simultaneous write and pop at FIFO_CNT=3: expect FIFO_CNT to stay 3 and pointer wrap past index 15 to be exercised with data intact.
- Busy timeout: model never raises Busy, one byte written. Expect the FSM back in IDLE after BUSY_TO cycles, and a second queued byte issued on the next cycle.
